// File: rtl/p2s_mux.sv
// p2s_mux: round-robin multi-channel ADC word serializer; first frame bit one clock after selection.
// No backpressure: a strobe into a still-pending channel is dropped and flagged in overrun.
module p2s_mux #(
  parameter int NUM_CH     = 8,
  parameter int BITS_ADC   = 12,
  parameter int HDR_EN     = 1,
  parameter int GAP_CYCLES = 2,
  localparam int CH_ID_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk_50M,
  input  logic                         rst_n,
  input  logic [NUM_CH*BITS_ADC-1:0]   p_data,
  input  logic [NUM_CH-1:0]            p_load,
  input  logic                         msb_first,
  input  logic                         ovr_clr,
  output logic                         s_data,
  output logic                         data_valid,
  output logic                         s_frame_n,
  output logic [CH_ID_BITS-1:0]        ch_id,
  output logic [NUM_CH-1:0]            p_ack,
  output logic [NUM_CH-1:0]            overrun,
  output logic                         busy
);

  localparam int SH_W  = CH_ID_BITS + BITS_ADC;
  localparam int CNT_W = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(CH_ID_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(BITS_ADC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [1:0]                        state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [SH_W-1:0]                   sh_q, sh_d;
  logic                              msb_q, msb_d;
  logic [NUM_CH-1:0]                 pend_q, pend_d;
  logic [NUM_CH-1:0][BITS_ADC-1:0]   wbuf_q, wbuf_d;
  logic [CH_ID_BITS-1:0]             ptr_q, ptr_d;
  logic                              s_data_q, s_data_d;
  logic                              dv_q, dv_d;
  logic                              sfn_q, sfn_d;
  logic                              busy_q, busy_d;
  logic [CH_ID_BITS-1:0]             ch_id_q, ch_id_d;
  logic [NUM_CH-1:0]                 p_ack_q, p_ack_d;
  logic [NUM_CH-1:0]                 ovr_q, ovr_d;

  logic                              sel_vld;
  logic [CH_ID_BITS-1:0]             sel_id;
  logic                              select_now;
  logic [NUM_CH-1:0]                 sel_clr;
  logic [NUM_CH-1:0]                 eff_pend;
  logic [NUM_CH-1:0]                 cap;
  logic [NUM_CH-1:0]                 ovr_set;
  logic [BITS_ADC-1:0]               word_sel;
  logic [SH_W-1:0]                   frm_msb, frm_lsb;
  logic                              nxt_bit;
  logic [SH_W-1:0]                   sh_shift;

  // Scan offsets high-to-low so the nearest pending channel at/after ptr wins.
  always_comb begin
    int j;
    j       = 0;
    sel_vld = 1'b0;
    sel_id  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (pend_q[j]) begin
        sel_vld = 1'b1;
        sel_id  = CH_ID_BITS'(j);
      end
    end
  end

  assign select_now = (state_q == ST_IDLE) && sel_vld;
  assign sel_clr    = select_now ? (NUM_CH'(1) << sel_id) : '0;

  // The channel leaving for the shifter this cycle is free to accept a new word.
  always_comb begin
    eff_pend = pend_q & ~sel_clr;
    cap      = p_load & ~eff_pend;
    ovr_set  = p_load & eff_pend;
    pend_d   = eff_pend | cap;
    p_ack_d  = cap;
    ovr_d    = (ovr_clr ? '0 : ovr_q) | ovr_set;
    wbuf_d   = wbuf_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cap[i]) wbuf_d[i] = p_data[i*BITS_ADC +: BITS_ADC];
    end
  end

  assign word_sel = wbuf_q[sel_id];
  assign frm_msb  = (HDR_EN != 0) ? {sel_id, word_sel} : {word_sel, {CH_ID_BITS{1'b0}}};
  assign frm_lsb  = (HDR_EN != 0) ? {word_sel, sel_id} : {{CH_ID_BITS{1'b0}}, word_sel};
  assign nxt_bit  = msb_q ? sh_q[SH_W-1] : sh_q[0];
  assign sh_shift = msb_q ? (sh_q << 1) : (sh_q >> 1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    msb_d    = msb_q;
    ptr_d    = ptr_q;
    ch_id_d  = ch_id_q;
    s_data_d = 1'b0;
    dv_d     = 1'b1;
    sfn_d    = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (sel_vld) begin
          msb_d   = msb_first;
          ch_id_d = sel_id;
          ptr_d   = (sel_id == CH_ID_BITS'(NUM_CH - 1)) ? '0 : sel_id + 1'b1;
          dv_d    = 1'b0;
          sfn_d   = 1'b0;
          if (msb_first) begin
            s_data_d = frm_msb[SH_W-1];
            sh_d     = frm_msb << 1;
          end else begin
            s_data_d = frm_lsb[0];
            sh_d     = frm_lsb >> 1;
          end
          if (HDR_EN != 0) begin
            state_d = ST_HDR;
            cnt_d   = HDR_LAST;
          end else begin
            state_d = ST_DATA;
            cnt_d   = DATA_LAST;
          end
        end
      end
      ST_HDR: begin
        dv_d     = 1'b0;
        s_data_d = nxt_bit;
        sh_d     = sh_shift;
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          cnt_d   = DATA_LAST;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
            cnt_d   = GAP_LAST;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          dv_d     = 1'b0;
          s_data_d = nxt_bit;
          sh_d     = sh_shift;
          cnt_d    = cnt_q - 1'b1;
        end
      end
      default: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      msb_q    <= 1'b1;
      pend_q   <= '0;
      wbuf_q   <= '0;
      ptr_q    <= '0;
      s_data_q <= 1'b0;
      dv_q     <= 1'b1;
      sfn_q    <= 1'b1;
      busy_q   <= 1'b0;
      ch_id_q  <= '0;
      p_ack_q  <= '0;
      ovr_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      msb_q    <= msb_d;
      pend_q   <= pend_d;
      wbuf_q   <= wbuf_d;
      ptr_q    <= ptr_d;
      s_data_q <= s_data_d;
      dv_q     <= dv_d;
      sfn_q    <= sfn_d;
      busy_q   <= busy_d;
      ch_id_q  <= ch_id_d;
      p_ack_q  <= p_ack_d;
      ovr_q    <= ovr_d;
    end
  end

  assign s_data     = s_data_q;
  assign data_valid = dv_q;
  assign s_frame_n  = sfn_q;
  assign ch_id      = ch_id_q;
  assign p_ack      = p_ack_q;
  assign overrun    = ovr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_p2s_mux.sv
// Directed bench for p2s_mux: a header-enabled instance and a data-only LSB-first instance.
module tb_p2s_mux;

  typedef struct packed {
    logic       d;
    logic       first;
    logic [2:0] ch;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [95:0] p_data;
  logic [7:0]  p_load_a, p_load_b;
  logic        msb_a, msb_b;
  logic        ovr_clr;
  logic        ovr_clr_b;

  logic        s_data_a, dv_a, sfn_a, busy_a;
  logic [2:0]  ch_id_a;
  logic [7:0]  p_ack_a, ovr_a;
  logic        s_data_b, dv_b, sfn_b, busy_b;
  logic [2:0]  ch_id_b;
  logic [7:0]  p_ack_b, ovr_b;

  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 0;
  exp_t qa[$];
  exp_t qb[$];
  int   idle_run_b = 0;
  int   b_frames   = 0;
  int   b_gaps     = 0;

  p2s_mux #(.NUM_CH(8), .BITS_ADC(12), .HDR_EN(1), .GAP_CYCLES(2)) u_dut_a (
    .clk_50M(clk), .rst_n(rst_n), .p_data(p_data), .p_load(p_load_a),
    .msb_first(msb_a), .ovr_clr(ovr_clr), .s_data(s_data_a), .data_valid(dv_a),
    .s_frame_n(sfn_a), .ch_id(ch_id_a), .p_ack(p_ack_a), .overrun(ovr_a), .busy(busy_a)
  );

  p2s_mux #(.NUM_CH(8), .BITS_ADC(12), .HDR_EN(0), .GAP_CYCLES(2)) u_dut_b (
    .clk_50M(clk), .rst_n(rst_n), .p_data(p_data), .p_load(p_load_b),
    .msb_first(msb_b), .ovr_clr(ovr_clr_b), .s_data(s_data_b), .data_valid(dv_b),
    .s_frame_n(sfn_b), .ch_id(ch_id_b), .p_ack(p_ack_b), .overrun(ovr_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_word(input int ch, input logic [11:0] w);
    p_data[ch*12 +: 12] = w;
  endtask

  // Expand one frame into expected serial bits, ordered by bit index.
  task automatic push_frame(input bit to_b, input int ch, input logic [11:0] w,
                            input bit msb, input bit hdr);
    exp_t       e;
    logic [2:0] id;
    bit         first;
    id    = 3'(ch);
    first = 1'b1;
    if (hdr) begin
      for (int i = 0; i < 3; i++) begin
        e.d = id[msb ? 2 - i : i]; e.first = first; e.ch = id; first = 1'b0;
        if (to_b) qb.push_back(e); else qa.push_back(e);
      end
    end
    for (int i = 0; i < 12; i++) begin
      e.d = w[msb ? 11 - i : i]; e.first = first; e.ch = id; first = 1'b0;
      if (to_b) qb.push_back(e); else qa.push_back(e);
    end
  endtask

  task automatic wait_drain_a(input int max);
    int n;
    n = 0;
    while ((qa.size() != 0 || busy_a !== 1'b0) && n < max) begin
      cyc(1);
      n++;
    end
    chk("drain_a", {qa.size() == 0, busy_a}, 2'b10);
  endtask

  task automatic wait_drain_b(input int max);
    int n;
    n = 0;
    while ((qb.size() != 0 || busy_b !== 1'b0) && n < max) begin
      cyc(1);
      n++;
    end
    chk("drain_b", {qb.size() == 0, busy_b}, 2'b10);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (dv_a === 1'b0) begin
        chk("a_unexpected_bit", 32'(qa.size() != 0), 1);
        if (qa.size() != 0) begin
          exp_t e;
          e = qa.pop_front();
          chk("a_bit", s_data_a, e.d);
          chk("a_frame_n", sfn_a, !e.first);
          chk("a_ch_id", ch_id_a, e.ch);
        end
      end else begin
        chk("a_idle", {s_data_a, sfn_a}, 2'b01);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (dv_b === 1'b0) begin
        chk("b_unexpected_bit", 32'(qb.size() != 0), 1);
        if (sfn_b === 1'b0 && b_frames > 0) begin
          chk("b_gap", idle_run_b, 3);
          b_gaps++;
        end
        if (sfn_b === 1'b0) b_frames++;
        idle_run_b = 0;
        if (qb.size() != 0) begin
          exp_t e;
          e = qb.pop_front();
          chk("b_bit", s_data_b, e.d);
          chk("b_frame_n", sfn_b, !e.first);
          chk("b_ch_id", ch_id_b, e.ch);
        end
      end else begin
        idle_run_b++;
        chk("b_idle", {s_data_b, sfn_b}, 2'b01);
      end
    end
  end

  initial begin
    int n, nb, act;
    rst_n = 1'b0; p_data = '0; p_load_a = '0; p_load_b = '0;
    msb_a = 1'b1; msb_b = 1'b0; ovr_clr = 1'b0; ovr_clr_b = 1'b0;
    cyc(3);
    chk("rst_s_data", s_data_a, 0);
    chk("rst_data_valid", dv_a, 1);
    chk("rst_frame_n", sfn_a, 1);
    chk("rst_ch_id", ch_id_a, 0);
    chk("rst_p_ack", p_ack_a, 0);
    chk("rst_overrun", ovr_a, 0);
    chk("rst_busy", busy_a, 0);
    rst_n = 1'b1; mon_en = 1'b1;

    // single word, MSB first with header; msb_first wiggles mid-frame
    set_word(5, 12'hA5C); p_load_a = 8'h20; push_frame(0, 5, 12'hA5C, 1, 1);
    cyc(1); chk("ack5", p_ack_a, 8'h20); p_load_a = '0;
    cyc(1); chk("ack5_pulse", p_ack_a, 8'h00); chk("busy_frame", busy_a, 1);
    cyc(2); msb_a = 1'b0; cyc(4); msb_a = 1'b1;
    wait_drain_a(60);

    // data-only LSB-first instance, two back-to-back frames
    set_word(0, 12'h001); set_word(1, 12'h80F); p_load_b = 8'h03;
    push_frame(1, 0, 12'h001, 0, 0); push_frame(1, 1, 12'h80F, 0, 0);
    cyc(1); chk("b_ack", p_ack_b, 8'h03); p_load_b = '0;
    wait_drain_b(80);
    chk("b_gap_seen", b_gaps, 1);

    // round robin from pointer 0
    rst_n = 1'b0; cyc(2); rst_n = 1'b1; cyc(1);
    set_word(2, 12'h123); set_word(6, 12'hFED); set_word(1, 12'h5A5); p_load_a = 8'h46;
    push_frame(0, 1, 12'h5A5, 1, 1); push_frame(0, 2, 12'h123, 1, 1); push_frame(0, 6, 12'hFED, 1, 1);
    cyc(1); chk("rr_ack", p_ack_a, 8'h46); p_load_a = '0;
    n = 0;
    while (!(dv_a === 1'b0 && ch_id_a === 3'd6) && n < 200) begin cyc(1); n++; end
    chk("rr_wait6", 32'(n < 200), 1);
    set_word(1, 12'h0F0); set_word(3, 12'h777); p_load_a = 8'h0A;
    push_frame(0, 1, 12'h0F0, 1, 1); push_frame(0, 3, 12'h777, 1, 1);
    cyc(1); chk("rr_ack2", p_ack_a, 8'h0A); p_load_a = '0;
    wait_drain_a(200);

    // overrun while ch0 frame is in flight
    set_word(0, 12'hC33); p_load_a = 8'h01; push_frame(0, 0, 12'hC33, 1, 1);
    cyc(1); p_load_a = '0; cyc(2);
    chk("ovr_busy", busy_a, 1);
    set_word(4, 12'h4A4); p_load_a = 8'h10; push_frame(0, 4, 12'h4A4, 1, 1);
    cyc(1); chk("ovr_ack1", p_ack_a, 8'h10); set_word(4, 12'hBBB);
    cyc(1); chk("ovr_noack", p_ack_a, 8'h00); chk("ovr_set", ovr_a, 8'h10);
    p_load_a = '0; ovr_clr = 1'b1;
    cyc(1); chk("ovr_clr", ovr_a, 8'h00); set_word(4, 12'hCCC); p_load_a = 8'h10;
    cyc(1); chk("ovr_set_wins", ovr_a, 8'h10); chk("ovr_noack2", p_ack_a, 8'h00);
    p_load_a = '0; ovr_clr = 1'b0;
    wait_drain_a(200);
    ovr_clr = 1'b1; cyc(1); ovr_clr = 1'b0; chk("ovr_clr2", ovr_a, 8'h00);

    // strobe on the selection edge of the same channel
    set_word(3, 12'h3A1); p_load_a = 8'h08; push_frame(0, 3, 12'h3A1, 1, 1);
    cyc(1); chk("same_ack1", p_ack_a, 8'h08);
    set_word(3, 12'h6B2); push_frame(0, 3, 12'h6B2, 1, 1);
    cyc(1); chk("same_ack2", p_ack_a, 8'h08); chk("same_noovr", ovr_a, 8'h00);
    chk("same_busy", busy_a, 1);
    p_load_a = '0;
    wait_drain_a(200);

    // reset on bit 6 of a frame, with another channel still pending
    set_word(2, 12'h3C3); set_word(7, 12'h1E1); p_load_a = 8'h84;
    push_frame(0, 7, 12'h1E1, 1, 1); push_frame(0, 2, 12'h3C3, 1, 1);
    cyc(1); p_load_a = '0;
    n = 0; nb = 0;
    while (nb < 6 && n < 100) begin cyc(1); n++; if (dv_a === 1'b0) nb++; end
    chk("rst_wait_bit6", nb, 6);
    rst_n = 1'b0;
    cyc(1);
    chk("mrst_data_valid", dv_a, 1);
    chk("mrst_s_data", s_data_a, 0);
    chk("mrst_busy", busy_a, 0);
    chk("mrst_frame_n", sfn_a, 1);
    chk("mrst_ch_id", ch_id_a, 0);
    qa.delete();
    rst_n = 1'b1;
    act = 0;
    repeat (40) begin cyc(1); if (dv_a !== 1'b1 || busy_a !== 1'b0) act++; end
    chk("no_frame_after_rst", act, 0);
    set_word(1, 12'h9E7); p_load_a = 8'h02; push_frame(0, 1, 12'h9E7, 1, 1);
    cyc(1); p_load_a = '0;
    wait_drain_a(100);
    chk("b_queue_empty", qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/p2s_mux.md
Name: p2s_mux

Overview:
- Multi-channel successor to the single-channel ADC parallel-to-serial converter.
- Accepts ADC words from NUM_CH column blocks into per-channel holding buffers.
- Selects pending channels round-robin and emits each word as one serial frame on a single line: optional channel-ID header, then data, MSB- or LSB-first.
- Runs entirely in the clk_50M domain. It uses a registered enable instead of a gated clock, so it replaces the gated-clock, dual-clock scheme.

Parameters:
- NUM_CH, 8, number of input channels (1..16).
- BITS_ADC, 12, data bits per word (4..16).
- HDR_EN, 1, 1 = prefix each frame with CH_ID_BITS channel-ID bits; 0 = data bits only.
- GAP_CYCLES, 2, minimum idle clocks between frames (0..15).
- Derived localparam CH_ID_BITS = max(1, clog2(NUM_CH)).

Ports:
- clk_50M  in  1  system clock; all logic samples on posedge.
- rst_n  in  1  synchronous, active-low reset.
- p_data  in  NUM_CH*BITS_ADC  packed words; channel i occupies bits [i*BITS_ADC +: BITS_ADC].
- p_load  in  NUM_CH  1-cycle strobe per channel; captures that channel's word.
- msb_first  in  1  bit order for header and data (1 = MSB first); sampled only at frame start.
- ovr_clr  in  1  1-cycle strobe; clears all overrun flags.
- s_data  out  1  serial data, registered.
- data_valid  out  1  active-low; 0 while s_data carries a frame bit.
- s_frame_n  out  1  active-low; 0 on the first bit of each frame only.
- ch_id  out  CH_ID_BITS  channel of the current frame; held until the next frame starts.
- p_ack  out  NUM_CH  registered 1-cycle pulse, one cycle after a successful capture.
- overrun  out  NUM_CH  sticky flag: a strobe arrived while that channel's buffer was still pending.
- busy  out  1  1 while state != IDLE.

Behaviour:
- Reset (rst_n=0 at posedge): effective at the next edge.
  - s_data=0, data_valid=1, s_frame_n=1, ch_id=0, p_ack=0, overrun=0, busy=0.
  - All pending flags cleared, RR pointer=0, state=IDLE.
  - Reset mid-frame aborts the frame; the next edge shows idle outputs. Words already captured are lost.
- Capture:
  - Condition: p_load[i]=1 and pending[i]=0 → buf[i]<=word i, pending[i]<=1, p_ack[i]=1 on the next cycle.
  - If p_load[i]=1 and pending[i]=1 → word dropped, buf unchanged, overrun[i]<=1, no ack.
  - Condition "pending" means the flag before any same-cycle clear. A strobe on the channel being loaded into the shifter that same cycle is therefore accepted.
  - ovr_clr together with a new overrun on the same cycle → overrun stays 1 (set wins).
- FSM states: IDLE, HDR, DATA, GAP.
  - IDLE: if any pending, select the first pending channel at or after the RR pointer (wrapping).
    - Load shifter with {id, buf} or buf alone, latch msb_first, ch_id<=id, clear pending[id].
    - RR pointer<=id+1 mod NUM_CH.
    - Go to HDR if HDR_EN, else DATA.
  - HDR: CH_ID_BITS cycles, then DATA.
  - DATA: BITS_ADC cycles, then GAP if GAP_CYCLES>0; otherwise IDLE.
  - GAP: GAP_CYCLES cycles with data_valid=1, then IDLE.
  - A pending channel never waits more than NUM_CH-1 frames.
- Latency and bit timing:
  - Selection edge T; first frame bit at T+1. Frame length is CH_ID_BITS*HDR_EN + BITS_ADC cycles.
  - s_frame_n=0 only at T+1. data_valid=0 on every frame bit.
  - A consumer samples s_data on posedge clk_50M whenever data_valid=0.
- Bit order:
  - msb_first=1: header MSB→LSB, then data MSB→LSB.
  - msb_first=0: header LSB→MSB, then data LSB→MSB.
  - msb_first changing mid-frame has no effect on the current frame.
- Idle/GAP: s_data=0, s_frame_n=1; ch_id holds the last value.
- Back-to-back throughput with GAP_CYCLES=0: next selection occurs in IDLE, so there is exactly 1 idle cycle between frames.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then single word: NUM_CH=8, HDR_EN=1, msb_first=1, load ch5=12'hA5C.
  - Expect p_ack[5] one cycle after the strobe.
  - Then 15 bits with data_valid=0: 101 then 1010_0101_1100; s_frame_n=0 on the first bit; ch_id=5.
- LSB-first, HDR_EN=0: load ch0=12'h001 → bits 1,0,0,0,0,0,0,0,0,0,0,0; data_valid high afterwards for GAP_CYCLES+1 cycles.
- Round-robin: strobe ch2, ch6, ch1 on the same cycle with pointer=0 → frame order 1,2,6.
  - Then reload ch1 and ch3 during frame 6 → next frames are 1 then 3 (pointer=7 wraps to 1).
- Overrun: load ch4, strobe ch4 again before its frame starts with a different word.
  - Expect overrun[4]=1, no second ack, original word serialised.
  - ovr_clr → overrun[4]=0; ovr_clr on the same cycle as a new overrun → stays 1.
- Reset mid-frame: assert rst_n=0 on bit 6 of a frame.
  - Next edge: data_valid=1, s_data=0, busy=0, pending cleared.
  - After release, no frame is emitted until a new p_load.
- Same-cycle capture/select: ch3 pending, and ch3 strobed on the IDLE selection edge.
  - Expect the old word serialised, the new word captured with p_ack[3], no overrun.
  - A second ch3 frame follows with the new word.
